// File: rtl/ms_uart_apb_v2.sv
// Second-generation APB UART: TX/RX engines, parametrised FIFOs, parity, 1/2 stop bits,
// RX idle timeout, error flags, internal loopback and a single level interrupt.

module ms_uart_apb_v2_fifo #(
   parameter int unsigned FAW = 4,
   parameter int unsigned W   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic [FAW:0] level,
   output logic         full,
   output logic         empty
);
   localparam int unsigned DEPTH = 1 << FAW;
   localparam logic [FAW:0] FULL_LVL = (FAW+1)'(DEPTH);

   logic [W-1:0]   mem [DEPTH];
   logic [FAW-1:0] wptr;
   logic [FAW-1:0] rptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + FAW'(1);
         if (do_pop)  rptr <= rptr + FAW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + (FAW+1)'(1);
            2'b01:   level <= level - (FAW+1)'(1);
            default: ;
         endcase
      end
   end

   // storage is not reset; only entries below level are ever observed
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

module ms_uart_apb_v2 #(
   parameter int unsigned FAW         = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   input  logic        RX,
   output logic        TX,
   output logic        irq
);
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tx_state_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
   typedef struct packed {logic fe; logic pe; logic [7:0] data;} rx_word_t;

   logic [15:0] prescale, pcnt, addr;
   logic [FAW:0] tx_tr, rx_tr, tx_level, rx_level;
   logic [7:0]  timeout, to_bits, tx_rdata, shr, shr_n, rshr;
   logic [6:0]  ctrl;
   logic [9:0]  im, ris, icr, ris_set;
   logic [31:0] status;
   logic [3:0]  tcnt, rcnt, to_sub;
   logic [2:0]  bidx, rbidx;
   logic [SYNC_STAGES-1:0] sync;
   tx_state_t   ts, ts_n;
   rx_state_t   rs, rs_n;
   rx_word_t    rx_head, rx_wr;
   logic en, txen, rxen, pen, podd, stop2, lpbk, wr, rd, tick, t_done, r_samp;
   logic tx_go, tx_pop, tx_full, tx_empty, rx_full, rx_empty, rx_push, rx_on;
   logic par, par_n, tx_line, tline_n, rx_in, rx_prev, rpar, pe_calc, to_fired, to_evt;
   logic unused_bits;

   assign {lpbk, stop2, podd, pen, rxen, txen, en} = ctrl;
   assign addr        = PADDR[15:0];
   assign wr          = PSEL && PENABLE && PWRITE;
   assign rd          = PSEL && PENABLE && !PWRITE;
   assign PREADY      = 1'b1;
   assign unused_bits = ^{PADDR[31:16], PWDATA[31:16]};

   // register file; ICR is a one-cycle pulse that clears RIS on the following edge
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         prescale <= '0; tx_tr <= '0; rx_tr <= '0; timeout <= '0;
         ctrl <= '0; im <= '0; icr <= '0; ris <= '0;
      end else begin
         icr <= '0;
         if (wr) begin
            case (addr)
               16'h0004: prescale <= PWDATA[15:0];
               16'h0008: tx_tr    <= PWDATA[FAW:0];
               16'h000C: rx_tr    <= PWDATA[FAW:0];
               16'h0010: timeout  <= PWDATA[7:0];
               16'h0100: ctrl     <= PWDATA[6:0];
               16'h0208: im       <= PWDATA[9:0];
               16'h020C: icr      <= PWDATA[9:0];
               default:  ;
            endcase
         end
         ris <= (ris | ris_set) & ~icr;
      end
   end

   always_comb begin
      status              = '0;
      status[FAW:0]       = tx_level;
      status[16+FAW:16]   = rx_level;
      status[31]          = (ts != T_IDLE);
      PRDATA              = 32'hDEADBEEF;
      case (addr)
         16'h0000: PRDATA = rx_empty ? 32'h0 : 32'(rx_head);
         16'h0004: PRDATA = 32'(prescale);
         16'h0008: PRDATA = 32'(tx_tr);
         16'h000C: PRDATA = 32'(rx_tr);
         16'h0010: PRDATA = 32'(timeout);
         16'h0100: PRDATA = 32'(ctrl);
         16'h0104: PRDATA = status;
         16'h0200: PRDATA = 32'(ris);
         16'h0204: PRDATA = 32'(ris & im);
         16'h0208: PRDATA = 32'(im);
         16'h020C: PRDATA = 32'h0;
         default:  ;
      endcase
   end

   assign irq = |(ris & im);

   ms_uart_apb_v2_fifo #(.FAW(FAW), .W(8)) u_txf (
      .clk(PCLK), .rst_n(PRESETn), .push(wr && addr == 16'h0000), .pop(tx_pop),
      .wdata(PWDATA[7:0]), .rdata(tx_rdata), .level(tx_level), .full(tx_full), .empty(tx_empty));

   ms_uart_apb_v2_fifo #(.FAW(FAW), .W(10)) u_rxf (
      .clk(PCLK), .rst_n(PRESETn), .push(rx_push), .pop(rd && addr == 16'h0000),
      .wdata(rx_wr), .rdata(rx_head), .level(rx_level), .full(rx_full), .empty(rx_empty));

   // baud tick: one every PRESCALE+1 cycles, 16 per bit
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) pcnt <= '0;
      else if (!en || pcnt == prescale) pcnt <= '0;
      else pcnt <= pcnt + 16'd1;
   end
   assign tick   = en && (pcnt == prescale);
   assign t_done = tick && (tcnt == 4'hF);
   assign tx_go  = en && txen && !tx_empty;

   always_comb begin
      ts_n = ts; tx_pop = 1'b0; shr_n = shr; par_n = par; tline_n = 1'b1;
      case (ts)
         T_IDLE:  if (tx_go) begin ts_n = T_START; tx_pop = 1'b1; end
         T_START: if (t_done) ts_n = T_DATA;
         T_DATA:  if (t_done) begin
                     shr_n = shr >> 1;
                     if (bidx == 3'd7) ts_n = pen ? T_PAR : T_STOP1;
                  end
         T_PAR:   if (t_done) ts_n = T_STOP1;
         T_STOP1, T_STOP2:
                  if (t_done) begin
                     if (ts == T_STOP1 && stop2) ts_n = T_STOP2;
                     else if (tx_go) begin ts_n = T_START; tx_pop = 1'b1; end
                     else ts_n = T_IDLE;
                  end
         default: ts_n = T_IDLE;
      endcase
      if (!en) begin ts_n = T_IDLE; tx_pop = 1'b0; end
      if (tx_pop) begin shr_n = tx_rdata; par_n = (^tx_rdata) ^ podd; end
      case (ts_n)
         T_START: tline_n = 1'b0;
         T_DATA:  tline_n = shr_n[0];
         T_PAR:   tline_n = par_n;
         default: tline_n = 1'b1;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ts <= T_IDLE; shr <= '0; par <= 1'b0; tx_line <= 1'b1; tcnt <= '0; bidx <= '0;
      end else begin
         ts <= ts_n; shr <= shr_n; par <= par_n; tx_line <= tline_n;
         tcnt <= (ts_n == T_IDLE) ? 4'd0 : (tick ? tcnt + 4'd1 : tcnt);
         if (ts != T_DATA || ts_n != T_DATA) bidx <= '0;
         else if (t_done) bidx <= bidx + 3'd1;
      end
   end

   assign TX = tx_line | lpbk;

   // loopback feeds the receiver even with RXEN clear
   assign rx_on   = en && (rxen || lpbk);
   assign rx_in   = lpbk ? tx_line : sync[SYNC_STAGES-1];
   assign r_samp  = tick && (rcnt == 4'd7);
   assign pe_calc = pen && (rpar != ((^rshr) ^ podd));
   assign rx_wr   = {!rx_in, pe_calc, rshr};

   always_comb begin
      rs_n = rs; rx_push = 1'b0;
      case (rs)
         R_IDLE:  if (rx_prev && !rx_in) rs_n = R_START;
         R_START: if (r_samp) rs_n = rx_in ? R_IDLE : R_DATA;
         R_DATA:  if (r_samp && rbidx == 3'd7) rs_n = pen ? R_PAR : R_STOP;
         R_PAR:   if (r_samp) rs_n = R_STOP;
         R_STOP:  if (r_samp) begin rs_n = R_IDLE; rx_push = 1'b1; end
         default: rs_n = R_IDLE;
      endcase
      if (!rx_on) begin rs_n = R_IDLE; rx_push = 1'b0; end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sync <= '1; rx_prev <= 1'b1; rs <= R_IDLE; rcnt <= '0; rbidx <= '0;
         rshr <= '0; rpar <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], RX};
         rx_prev <= rx_in;
         rs      <= rs_n;
         rcnt    <= (rs_n == R_IDLE) ? 4'd0 : (tick ? rcnt + 4'd1 : rcnt);
         if (rs != R_DATA || rs_n != R_DATA) rbidx <= '0;
         else if (r_samp) rbidx <= rbidx + 3'd1;
         if (rs == R_DATA && r_samp) rshr <= {rx_in, rshr[7:1]};
         if (rs == R_PAR && r_samp)  rpar <= rx_in;
      end
   end

   // idle timeout in bit periods, restarted by any RX FIFO push or pop, fires once
   assign to_evt = (timeout != 8'd0) && !rx_empty && (to_bits == timeout) && !to_fired;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         to_sub <= '0; to_bits <= '0; to_fired <= 1'b0;
      end else if ((rx_push && !rx_full) || (rd && addr == 16'h0000 && !rx_empty)) begin
         to_sub <= '0; to_bits <= '0; to_fired <= 1'b0;
      end else begin
         if (tick) begin
            to_sub <= to_sub + 4'd1;
            if (to_sub == 4'hF && to_bits != 8'hFF) to_bits <= to_bits + 8'd1;
         end
         if (to_evt) to_fired <= 1'b1;
      end
   end

   assign ris_set = {rx_push && rx_full, rx_push && !rx_in, rx_push && pe_calc, to_evt,
                     rx_level > rx_tr, rx_empty, rx_full, tx_level < tx_tr, tx_empty, tx_full};
endmodule

// File: tb/tb_ms_uart_apb_v2.sv
// Directed bench for ms_uart_apb_v2: registers, loopback, parity/stop, RX errors,
// overflow, timeout interrupt and mid-frame abort.

module tb_ms_uart_apb_v2;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0, prdata;
   logic        pready, tx_pin, irq;
   logic        rx_drv = 1'b1, rx_loop = 1'b0;
   logic        rx_pin;
   logic [31:0] v;
   int          n_chk = 0, n_pass = 0;
   int          lat;
   logic        tx_low;

   localparam logic [15:0] A_DATA = 16'h0000, A_PRE = 16'h0004, A_TO = 16'h0010,
                           A_CTRL = 16'h0100, A_STAT = 16'h0104, A_RIS = 16'h0200,
                           A_MIS = 16'h0204, A_IM = 16'h0208, A_ICR = 16'h020C;

   always #5 clk = ~clk;
   assign rx_pin = rx_loop ? tx_pin : rx_drv;

   ms_uart_apb_v2 #(.FAW(4), .SYNC_STAGES(2)) dut (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
      .RX(rx_pin), .TX(tx_pin), .irq(irq));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {16'h0, a}; pwdata = d;
      @(posedge clk); #1; penable = 1'b1;
      @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {16'h0, a};
      @(posedge clk); #1; penable = 1'b1; #1 d = prdata;
      @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] d;
      apb_read(a, d);
      chk(tag, d, exp);
   endtask

   task automatic drive_bit(input logic b);
      @(posedge clk); #1; rx_drv = b;
      repeat (15) @(posedge clk);
   endtask

   // 8N1 frame at 16 cycles per bit, stop level selectable
   task automatic send_frame(input logic [7:0] b, input logic stopv);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stopv);
      @(posedge clk); #1; rx_drv = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;

      // reset state
      chk("rst_tx", 32'(tx_pin), 32'd1);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_pready", 32'(pready), 32'd1);
      rd_chk("rst_ctrl", A_CTRL, 32'h0);
      rd_chk("rst_status", A_STAT, 32'h0);
      rd_chk("rst_ris", A_RIS, 32'h12);
      rd_chk("rst_icr_read", A_ICR, 32'h0);
      rd_chk("bad_addr", 16'h0300, 32'hDEADBEEF);

      // loopback 8N1
      apb_write(A_PRE, 32'd0);
      apb_write(A_CTRL, 32'h43);
      apb_write(A_DATA, 32'hA5);
      tx_low = 1'b0;
      repeat (200) begin @(posedge clk); #1; if (!tx_pin) tx_low = 1'b1; end
      chk("lb_tx_pin_idle", 32'(tx_low), 32'd0);
      rd_chk("lb_status", A_STAT, 32'h0001_0000);
      rd_chk("lb_data", A_DATA, 32'h0A5);
      rd_chk("lb_status_after_pop", A_STAT, 32'h0);

      // odd parity, two stop bits: 12-bit frame
      apb_write(A_CTRL, 32'h7F);
      apb_write(A_DATA, 32'h03);
      repeat (180) @(posedge clk);
      apb_read(A_STAT, v);
      chk("par_busy_at_182", 32'(v[31]), 32'd1);
      repeat (12) @(posedge clk);
      apb_read(A_STAT, v);
      chk("par_idle_at_198", 32'(v[31]), 32'd0);
      rd_chk("par_data", A_DATA, 32'h003);
      apb_read(A_RIS, v);
      chk("par_ris_pe", 32'(v[7]), 32'd0);

      // external RX framing error and glitch rejection
      apb_write(A_CTRL, 32'h05);
      apb_write(A_ICR, 32'h3FF);
      send_frame(8'h3C, 1'b0);
      repeat (4) @(posedge clk);
      apb_read(A_RIS, v);
      chk("fe_ris_pe_fe", 32'(v[8:7]), 32'd2);
      rd_chk("fe_data", A_DATA, 32'h23C);
      @(posedge clk); #1 rx_drv = 1'b0;
      repeat (4) @(posedge clk); #1 rx_drv = 1'b1;
      repeat (200) @(posedge clk);
      rd_chk("glitch_no_push", A_STAT, 32'h0);

      // overflow: 17 frames into a 16-entry FIFO
      apb_write(A_ICR, 32'h3FF);
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
      repeat (4) @(posedge clk);
      rd_chk("ovf_status", A_STAT, 32'h0010_0000);
      apb_read(A_RIS, v);
      chk("ovf_ris_full_ovr", v & 32'h208, 32'h208);
      apb_write(A_ICR, 32'h200);
      apb_read(A_RIS, v);
      chk("ovf_icr_clear", v & 32'h208, 32'h008);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("ovf_byte%0d", i), A_DATA, 32'(i));
      rd_chk("ovf_drained", A_STAT, 32'h0);

      // RX idle timeout interrupt
      apb_write(A_TO, 32'd4);
      apb_write(A_IM, 32'h40);
      apb_write(A_ICR, 32'h3FF);
      send_frame(8'h5A, 1'b1);
      chk("to_irq_low_at_frame_end", 32'(irq), 32'd0);
      lat = -1;
      for (int n = 1; n <= 150; n++) begin
         @(posedge clk); #1;
         if (irq) begin lat = n; break; end
      end
      chk("to_irq_latency_window", 32'(lat >= 44 && lat <= 76), 32'd1);
      rd_chk("to_mis", A_MIS, 32'h40);
      rd_chk("to_data", A_DATA, 32'h05A);
      apb_write(A_ICR, 32'h40);
      repeat (2) @(posedge clk); #1;
      chk("to_irq_cleared", 32'(irq), 32'd0);

      // mid-frame abort keeps FIFO contents, re-enable sends the rest
      apb_write(A_IM, 32'h0);
      apb_write(A_CTRL, 32'h03);
      apb_write(A_DATA, 32'h00);
      for (int i = 1; i < 8; i++) apb_write(A_DATA, 32'(8'h10 + 8'(i)));
      repeat (40) @(posedge clk); #1;
      chk("abort_pre_tx_low", 32'(tx_pin), 32'd0);
      apb_write(A_CTRL, 32'h02);
      @(posedge clk); #1;
      chk("abort_tx_high", 32'(tx_pin), 32'd1);
      rd_chk("abort_status", A_STAT, 32'h0000_0007);
      rx_loop = 1'b1;
      apb_write(A_CTRL, 32'h07);
      repeat (7 * 160 + 100) @(posedge clk);
      rd_chk("resume_status", A_STAT, 32'h0007_0000);
      for (int i = 1; i < 8; i++)
         rd_chk($sformatf("resume_byte%0d", i), A_DATA, 32'(8'h10 + 8'(i)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ms_uart_apb_v2.md
Name: ms_uart_apb_v2

Overview:
Second-generation APB UART. It integrates the TX/RX engines, FIFOs of parametrised depth, and the register file in one block. Compared with the current APB UART it adds configurable parity, 1 or 2 stop bits, an RX idle timeout, parity/framing/overrun error detection and internal loopback. It sits on the peripheral APB bus and drives one level interrupt to the system interrupt controller.

Parameters:
FAW, 4, FIFO address width; each FIFO holds 2^FAW entries; level fields are FAW+1 bits.
SYNC_STAGES, 2, number of RX input synchroniser flops (minimum 2).

Ports:
PCLK  in  1  clock; the only clock.
PRESETn  in  1  asynchronous active-low reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PWRITE  in  1  APB write.
PADDR  in  32  APB address; only [15:0] decoded.
PWDATA  in  32  APB write data.
PRDATA  out  32  APB read data (combinational from PADDR).
PREADY  out  1  tied to 1.
RX  in  1  serial input; asynchronous, idle high.
TX  out  1  serial output; idle high.
irq  out  1  OR of MIS.

Behaviour:
- APB access: access = PSEL&PENABLE; zero wait states.
- Reset: all registers are 0; FIFOs are empty; both engines are in IDLE; TX=1; irq=0.
- Register map:
  - 0x0000 DATA: a write pushes PWDATA[7:0] to the TX FIFO and is dropped if the FIFO is full. A read pops the RX FIFO and returns {22'b0, FE, PE, data[7:0]}. A read while empty returns 0 and does not pop.
  - 0x0004 PRESCALE[15:0].
  - 0x0008 TXFIFOTR[FAW:0].
  - 0x000C RXFIFOTR[FAW:0].
  - 0x0010 TIMEOUT[7:0], counted in bit periods.
  - 0x0100 CTRL: b0 EN, b1 TXEN, b2 RXEN, b3 PEN, b4 PODD, b5 STOP2, b6 LOOPBACK.
  - 0x0104 STATUS (read-only): [FAW:0] tx_level, [16+FAW:16] rx_level, b31 tx_busy.
  - 0x0200 RIS, 0x0204 MIS = RIS&IM, 0x0208 IM[9:0].
  - 0x020C ICR: write-only, reads 0, a one-cycle pulse.
  - Any other address reads 0xDEADBEEF.
- RIS bits:
  - 0 TX full, 1 TX empty, 2 TX level < TXFIFOTR, 3 RX full, 4 RX empty, 5 RX level > RXFIFOTR: set on every cycle the condition holds.
  - 6 RX timeout, 7 parity error, 8 framing error, 9 RX overrun: set on the event pulse.
  - An ICR bit clears the RIS bit on the cycle after the write. The clear wins over a set in that same cycle. A level condition that persists re-sets the bit one cycle later.
- Tick generator:
  - Runs only while EN=1. One tick every PRESCALE+1 PCLK cycles.
  - One bit = 16 ticks.
  - EN=0 holds the counter at 0.
- TX engine:
  - States: IDLE -> START -> DATA(8 bits, LSB first) -> PARITY (only if PEN) -> STOP1 -> STOP2 (only if STOP2) -> IDLE.
  - Leaves IDLE when EN&TXEN and the TX FIFO is not empty. The pop happens on the IDLE->START transition.
  - Parity bit = XOR of the data, inverted when PODD=1.
  - tx_busy = state != IDLE.
  - Back-to-back frames have no idle gap.
- RX engine:
  - Input path: RX passes through SYNC_STAGES flops. When LOOPBACK=1, the engine input is the internal TX and the TX pin is held at 1.
  - States: IDLE -> START -> DATA -> PARITY (only if PEN) -> STOP -> IDLE.
  - START: entered on a falling edge while EN&RXEN. The line is re-sampled 8 ticks later; if it is high, this is a false start and the engine returns to IDLE.
  - Each following bit is sampled 16 ticks after the previous sample.
  - STOP: sample = 0 gives FE=1 and sets RIS[8]; a parity mismatch gives PE=1 and sets RIS[7]. Only the first stop bit is checked.
  - The word {FE, PE, data} is pushed at the stop-bit sample. If the RX FIFO is full, the word is discarded and RIS[9] is set.
- Timeout:
  - A bit-period counter resets on any RX FIFO push or pop.
  - When TIMEOUT != 0, the RX FIFO is not empty, and the count == TIMEOUT, RIS[6] is set once. It does not fire again until the next push or pop.
- FIFOs:
  - Pointers wrap modulo 2^FAW. Level ranges 0..2^FAW.
  - A push and a pop in the same cycle are both performed; the level is unchanged. A push is blocked only when full before the pop.
- Mid-operation: EN cleared mid-frame aborts both engines to IDLE within one cycle, TX returns to 1, and the partial RX word is discarded. FIFO contents are kept.
- Reset asserted mid-frame: everything returns to reset values immediately.

Test Plan:
- Setup: PRESCALE=0 (16 cycles/bit), CTRL=0x43 (EN, TXEN, LOOPBACK). Write DATA=0xA5 -> TX pin stays 1. After the 10-bit frame, RX FIFO level=1 and a DATA read returns 0x0A5.
- Parity and stop bits: CTRL=0x7F (adds PEN, PODD, STOP2, RXEN), write 0x03 -> frame of 12 bits with parity bit 1. Read returns 0x003, PE=0.
- External RX, 8N1 at 16 cycles/bit: drive 0x3C with stop bit forced 0 -> read returns 0x23C and RIS[8]=1. A 4-cycle low glitch instead -> no push.
- Overflow, FAW=4, RX idle: 17 frames received -> level 16, RIS[3]=1, RIS[9]=1, and the 17th byte is lost. Write ICR=0x200 -> RIS[9]=0, while RIS[3] is re-set next cycle.
- Timeout: TIMEOUT=4, IM=0x40, one byte received -> irq rises 4 bit periods (64 cycles, ±1 bit) after the push. A DATA read, then ICR=0x40 -> irq=0.
- Abort: 8 TX writes, clear EN after 40 cycles -> TX=1 within 1 cycle and TX level=7. Re-enable -> the remaining 7 frames are sent.
